// File: rtl/bit_balancer_pipe.sv
// Two-stage pipelined bit balancer: per-byte popcounts in S1, summed result plus
// balance/imbalance and a saturating ones accumulator in S2, valid/ready on both sides.
module bit_balancer_pipe #(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned ACC_W = 12,
    localparam int unsigned CW = $clog2(WIDTH + 1)
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [WIDTH-1:0]    in_data,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [CW-1:0]       count,
    output logic                balanced,
    output logic signed [CW:0]  imbalance,
    input  logic                acc_en,
    input  logic                acc_clr,
    output logic [ACC_W-1:0]    acc_total,
    output logic                acc_sat
);
    localparam int unsigned NB = WIDTH / 8;
    localparam int unsigned SW = ACC_W + 1;

    logic               advance;
    logic               s1_valid;
    logic               s2_load;
    logic [NB-1:0][3:0] byte_cnt_c;
    logic [NB-1:0][3:0] s1_cnt;
    logic [CW-1:0]      sum_c;
    logic [CW:0]        imb_c;
    logic [SW-1:0]      acc_sum_c;

    // Whole pipe moves in lockstep; a stalled output freezes every stage.
    assign advance  = !out_valid || out_ready;
    assign in_ready = advance;
    assign s2_load  = advance && s1_valid;

    // Per-byte popcount of the incoming word.
    always_comb begin
        byte_cnt_c = '0;
        for (int b = 0; b < int'(NB); b++) begin
            for (int i = 0; i < 8; i++) begin
                byte_cnt_c[b] = byte_cnt_c[b] + 4'(in_data[b*8 + i]);
            end
        end
    end

    // Sum of the registered byte counts and derived result fields.
    always_comb begin
        sum_c = '0;
        for (int b = 0; b < int'(NB); b++) begin
            sum_c = sum_c + CW'(s1_cnt[b]);
        end
        imb_c     = {sum_c, 1'b0} - (CW+1)'(WIDTH);
        acc_sum_c = SW'(acc_total) + SW'(sum_c);
    end

    // S1: byte counts only reload on a real word so idle data never goes X.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            s1_valid <= 1'b0;
            s1_cnt   <= '0;
        end else if (advance) begin
            s1_valid <= in_valid;
            if (in_valid) begin
                s1_cnt <= byte_cnt_c;
            end
        end
    end

    // S2: output register, holds the last valid result through bubbles and stalls.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            out_valid <= 1'b0;
            count     <= '0;
            balanced  <= 1'b0;
            imbalance <= '0;
        end else if (advance) begin
            out_valid <= s1_valid;
            if (s1_valid) begin
                count     <= sum_c;
                balanced  <= (sum_c == CW'(WIDTH / 2));
                imbalance <= imb_c;
            end
        end
    end

    // Accumulator: adds only when S2 loads, so a held result is never counted twice.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            acc_total <= '0;
            acc_sat   <= 1'b0;
        end else if (acc_clr) begin
            acc_total <= (s2_load && acc_en) ? ACC_W'(sum_c) : '0;
            acc_sat   <= 1'b0;
        end else if (s2_load && acc_en) begin
            if (acc_sum_c[ACC_W]) begin
                acc_total <= '1;
                acc_sat   <= 1'b1;
            end else begin
                acc_total <= acc_sum_c[ACC_W-1:0];
            end
        end
    end

endmodule

// File: tb/tb_bit_balancer_pipe.sv
// Scoreboard bench for bit_balancer_pipe (WIDTH=16, ACC_W=8): directed words with
// hand-computed counts; a negedge monitor pops expectations on each output transfer.
module tb_bit_balancer_pipe;
    localparam int unsigned WIDTH = 16;
    localparam int unsigned ACC_W = 8;

    logic               clk;
    logic               reset;
    logic               in_valid;
    logic               in_ready;
    logic [15:0]        in_data;
    logic               out_valid;
    logic               out_ready;
    logic [4:0]         count;
    logic               balanced;
    logic signed [5:0]  imbalance;
    logic               acc_en;
    logic               acc_clr;
    logic [7:0]         acc_total;
    logic               acc_sat;

    typedef struct {
        logic [4:0]        cnt;
        logic              bal;
        logic signed [5:0] imb;
        logic [7:0]        acc;
        logic              sat;
        bit                chk_acc;
        int                exp_cyc;
    } exp_t;

    exp_t sb[$];
    int   nchk  = 0;
    int   nerr  = 0;
    int   cyc   = 0;
    int   m_acc = 0;
    bit   m_sat = 1'b0;

    bit_balancer_pipe #(.WIDTH(WIDTH), .ACC_W(ACC_W)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .count     (count),
        .balanced  (balanced),
        .imbalance (imbalance),
        .acc_en    (acc_en),
        .acc_clr   (acc_clr),
        .acc_total (acc_total),
        .acc_sat   (acc_sat)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic signed [31:0] act, input logic signed [31:0] exp);
        nchk++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        in_valid = 1'b0;
        repeat (4) step();
    endtask

    // Offer one word; once accepted, update the accumulator model with the
    // acc_en/acc_clr values the caller arranges for this word's S2 load edge.
    task automatic send(input logic [15:0] d, input int c, input bit ld_en, input bit ld_clr,
                        input bit chk_acc, input bit lat);
        exp_t e;
        bit   took;
        int   n;
        took = 1'b0;
        n = 0;
        in_valid = 1'b1;
        in_data = d;
        while (!took && n < 50) begin
            @(negedge clk);
            took = in_ready;
            @(posedge clk);
            #1;
            n++;
        end
        in_valid = 1'b0;
        if (!took) begin
            nchk++;
            nerr++;
            $display("FAIL accept_timeout: word %h not accepted, expected accept within 50 cycles", d);
            return;
        end
        if (ld_clr) begin
            m_acc = ld_en ? c : 0;
            m_sat = 1'b0;
        end else if (ld_en) begin
            if (m_acc + c > 255) begin
                m_acc = 255;
                m_sat = 1'b1;
            end else begin
                m_acc = m_acc + c;
            end
        end
        e.cnt     = 5'(c);
        e.bal     = (c == 8);
        e.imb     = 6'(2 * c - 16);
        e.acc     = 8'(m_acc);
        e.sat     = m_sat;
        e.chk_acc = chk_acc;
        e.exp_cyc = lat ? cyc + 1 : -1;
        sb.push_back(e);
    endtask

    // Monitor: a transfer happens on the next rising edge when valid && ready here.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (reset && out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    nchk++;
                    nerr++;
                    $display("FAIL unexpected_output: count=%0d with empty scoreboard, expected no output", count);
                end else begin
                    e = sb.pop_front();
                    chk("count", 32'(count), 32'(e.cnt));
                    chk("balanced", 32'(balanced), 32'(e.bal));
                    chk("imbalance", 32'(imbalance), 32'(e.imb));
                    if (e.chk_acc) begin
                        chk("acc_total", 32'(acc_total), 32'(e.acc));
                        chk("acc_sat", 32'(acc_sat), 32'(e.sat));
                    end
                    if (e.exp_cyc >= 0) begin
                        chk("latency_cycle", cyc, e.exp_cyc);
                    end
                end
            end
        end
    end

    initial begin
        #20000;
        $display("FAIL watchdog: simulation still running at %0t, expected finish earlier", $time);
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset = 1'b0;
        in_valid = 1'b0;
        in_data = '0;
        out_ready = 1'b0;
        acc_en = 1'b0;
        acc_clr = 1'b0;
        #3;
        chk("rst_out_valid", 32'(out_valid), 0);
        chk("rst_count", 32'(count), 0);
        chk("rst_acc_total", 32'(acc_total), 0);
        chk("rst_acc_sat", 32'(acc_sat), 0);
        chk("rst_in_ready", 32'(in_ready), 1);
        @(negedge clk);
        reset = 1'b1;
        step();
        out_ready = 1'b1;

        // Back-to-back words, accumulator off.
        send(16'hFFFF, 16, 1'b0, 1'b0, 1'b1, 1'b1);
        send(16'h00FF, 8, 1'b0, 1'b0, 1'b1, 1'b1);
        send(16'h0001, 1, 1'b0, 1'b0, 1'b1, 1'b1);
        drain();

        // Backpressure: output stalls with the first result held.
        out_ready = 1'b0;
        send(16'h0F0F, 8, 1'b0, 1'b0, 1'b1, 1'b0);
        send(16'h0003, 2, 1'b0, 1'b0, 1'b1, 1'b0);
        fork
            send(16'h8000, 1, 1'b0, 1'b0, 1'b1, 1'b0);
            begin
                step();
                chk("bp_in_ready", 32'(in_ready), 0);
                chk("bp_out_valid", 32'(out_valid), 1);
                chk("bp_count", 32'(count), 8);
                step();
                chk("bp_hold_count", 32'(count), 8);
                chk("bp_hold_balanced", 32'(balanced), 1);
                out_ready = 1'b1;
            end
        join
        drain();

        // Saturation: 16 all-ones words into an 8-bit accumulator.
        acc_en = 1'b1;
        for (int i = 0; i < 16; i++) begin
            send(16'hFFFF, 16, 1'b1, 1'b0, 1'b1, 1'b1);
        end
        drain();
        chk("sat_sticky", 32'(acc_sat), 1);

        // Clear on the load of a count-4 word, then a word with acc_en low.
        send(16'h000F, 4, 1'b1, 1'b1, 1'b1, 1'b1);
        acc_clr = 1'b1;
        send(16'h0707, 6, 1'b0, 1'b0, 1'b1, 1'b1);
        acc_clr = 1'b0;
        acc_en = 1'b0;
        step();
        drain();
        chk("en_off_acc_total", 32'(acc_total), 4);

        // Clear while the output is stalled; held result must not be re-added.
        acc_en = 1'b1;
        out_ready = 1'b0;
        send(16'h0003, 2, 1'b1, 1'b0, 1'b0, 1'b0);
        step();
        chk("stall_out_valid", 32'(out_valid), 1);
        chk("stall_acc_total", 32'(acc_total), 32'(m_acc));
        acc_clr = 1'b1;
        step();
        m_acc = 0;
        m_sat = 1'b0;
        acc_clr = 1'b0;
        chk("stall_clr_acc_total", 32'(acc_total), 0);
        chk("stall_clr_count", 32'(count), 2);
        chk("stall_clr_in_ready", 32'(in_ready), 0);
        out_ready = 1'b1;
        drain();
        chk("no_readd_acc_total", 32'(acc_total), 0);

        // Asynchronous reset with two words in flight.
        send(16'h00F0, 4, 1'b1, 1'b0, 1'b1, 1'b1);
        send(16'h1111, 4, 1'b1, 1'b0, 1'b1, 1'b1);
        chk("inflight_out_valid", 32'(out_valid), 1);
        chk("inflight_acc_total", 32'(acc_total), 4);
        #2;
        reset = 1'b0;
        #1;
        chk("async_rst_out_valid", 32'(out_valid), 0);
        chk("async_rst_acc_total", 32'(acc_total), 0);
        chk("async_rst_count", 32'(count), 0);
        chk("async_rst_in_ready", 32'(in_ready), 1);
        sb.delete();
        m_acc = 0;
        m_sat = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        step();
        send(16'h0101, 2, 1'b1, 1'b0, 1'b1, 1'b1);
        drain();
        chk("post_rst_acc_total", 32'(acc_total), 2);
        chk("scoreboard_empty", sb.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
        $finish;
    end

endmodule

// File: doc/bit_balancer_pipe.md
Name: bit_balancer_pipe

Overview:
Parametrised, pipelined successor to the 8-bit registered bit balancer. Each accepted WIDTH-bit word yields its ones count, a balance flag and a signed ones-minus-zeros imbalance. A mode-selectable running accumulator of ones across accepted words saturates on overflow. It sits in the streaming datapath with valid/ready handshakes on both sides, so upstream and downstream can stall it.

Parameters:
WIDTH, 16, input word width; multiple of 8, legal range 8..64.
ACC_W, 12, accumulator width; must be at least CW.
(derived) CW = $clog2(WIDTH+1), the width of the count output.

Ports:
clk  input  1  rising-edge clock
reset  input  1  asynchronous, active-low reset
in_valid  input  1  upstream word valid
in_ready  output  1  block can accept a word this cycle
in_data  input  WIDTH  word to analyse
out_valid  output  1  result valid
out_ready  input  1  downstream accepts the result
count  output  CW  number of 1 bits in the word
balanced  output  1  1 when count == WIDTH/2
imbalance  output  CW+1  signed, 2*count - WIDTH
acc_en  input  1  accumulate mode enable
acc_clr  input  1  synchronous accumulator clear
acc_total  output  ACC_W  running ones total, saturating
acc_sat  output  1  sticky flag, accumulator has saturated

Behaviour:
- Reset: reset low immediately, without waiting for a clock edge, sets:
  - all stage valids, out_valid, count, balanced, imbalance, acc_total and acc_sat to 0.
  - in_ready to 1 (in_ready is combinational from out_valid).
  - reset mid-stream drops all in-flight words; none are replayed.
- Pipeline: two register stages.
  - S1 registers per-byte popcounts (4 bits each) plus s1_valid.
  - S2 is the output register: it sums the byte counts and drives count, balanced, imbalance and out_valid.
- Advance: advance = !out_valid || out_ready, and in_ready = advance.
  - When advance=0, every stage holds; bubbles are not collapsed.
  - When advance=1, S1 loads in_data's byte counts with s1_valid = in_valid, and S2 loads from S1 with out_valid = s1_valid.
  - A word is accepted on an edge where in_valid && in_ready.
- Latency: a word accepted at edge N shows out_valid=1 with its result after edge N+1, provided there is no stall. That is 2 register stages.
- Data hold: results are held stable while out_valid && !out_ready. Output fields are don't-care when out_valid=0; implementations must still drive them deterministically, with no X.
- imbalance: two's complement, range -WIDTH..+WIDTH. For example, WIDTH=16 with count=0 gives -16.
- Accumulator update, on each edge where S2 loads a valid word (advance && s1_valid):
  - acc_clr=1: acc_total = (acc_en ? new count : 0) and acc_sat = 0.
  - otherwise, acc_en=1: acc_total = min(acc_total + count, 2^ACC_W - 1). acc_sat is set when the true sum exceeds 2^ACC_W - 1, and stays set until cleared.
  - acc_en=0: acc_total holds.
- acc_clr on an edge with no valid S2 load: acc_total = 0 and acc_sat = 0.
- acc_total is updated in the same edge as the corresponding count and is visible with it.
- Simultaneous events: a stall combined with acc_clr still clears, because the clear does not depend on advance. The accumulator never counts a held result twice.

Test Plan:
- Reset with WIDTH=16 and ACC_W=8 -> out_valid=0, count=0, acc_total=0, acc_sat=0, in_ready=1.
- out_ready=1, send 16'hFFFF then 16'h00FF then 16'h0001 back-to-back -> results appear on consecutive cycles starting 2 edges after the first accept:
  - count=16, imbalance=+16, balanced=0
  - count=8, imbalance=0, balanced=1
  - count=1, imbalance=-14, balanced=0
- Backpressure: hold out_ready=0 while streaming 16'h0F0F, 16'h0003, 16'h8000 -> once out_valid=1, in_ready=0 and outputs hold at count=8. Then release out_ready -> results 8, 2, 1 appear in order, none lost or duplicated.
- acc_en=1, 16 consecutive 16'hFFFF words -> acc_total is 240 after the 15th word and 255 after the 16th, with acc_sat=1. A later word with acc_clr=1 and count=4 gives acc_total=4, acc_sat=0.
- acc_en=0 mid-stream -> acc_total unchanged while count still updates. Stall with acc_clr=1 -> acc_total=0, and the held result is not re-added after release.
- Drop reset low between clock edges with two words in flight -> out_valid and acc_total go to 0 immediately. After reset is released, the first new word gives a correct result 2 edges after acceptance.
